// File: rtl/pifo_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pifo_sram_pkg
// Purpose  : Shared types and helpers for the PIFO per-level SRAM bank:
//            the FSM state enum, entry-width helpers and the construction
//            of the "empty" entry value that the init sweep writes.
// Revision : 1.0 - initial release
// ============================================================================
package pifo_sram_pkg;

    // Upper bound on entry width handled by the constant helpers below.
    localparam int MAX_DW = 1024;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // Half-entry width: {size, metadata, value}.
    function automatic int calc_hw(input int ptw, input int mtw, input int ctw);
        return ctw + mtw + ptw;
    endfunction

    // Full entry holds two slots.
    function automatic int calc_dw(input int ptw, input int mtw, input int ctw);
        return 2 * calc_hw(ptw, mtw, ctw);
    endfunction

    // Empty half-entry: counter and metadata zero, payload all ones.
    // Returned zero-extended to MAX_DW; callers slice to their width.
    function automatic logic [MAX_DW-1:0] empty_half(input int ptw);
        logic [MAX_DW-1:0] h;
        h = '0;
        for (int i = 0; i < ptw && i < MAX_DW; i++) begin
            h[i] = 1'b1;
        end
        return h;
    endfunction

    // Empty entry: two empty halves packed side by side.
    function automatic logic [MAX_DW-1:0] empty_entry(input int ptw, input int mtw,
                                                      input int ctw);
        logic [MAX_DW-1:0] h;
        h = empty_half(ptw);
        return h | (h << calc_hw(ptw, mtw, ctw));
    endfunction

endpackage
`default_nettype wire

// File: rtl/pifo_sram_array.sv
`default_nettype none
// ============================================================================
// Module   : pifo_sram_array
// Purpose  : Plain 1R1W synchronous storage with a registered read port.
//            Contents are not reset. Read-first: a read and a write to the
//            same address at the same edge returns the old contents.
//            Replaceable by a vendor SRAM macro with the same port behaviour.
// Ports    : clk_i            clock
//            we_i/waddr_i/wdata_i   write port
//            re_i/raddr_i     read request/address
//            rdata_o          read data, updated only at an edge with re_i
// Revision : 1.0 - initial release
// ============================================================================
module pifo_sram_array #(
    parameter int ADW = 4,
    parameter int DW  = 52
) (
    input  logic           clk_i,
    input  logic           we_i,
    input  logic [ADW-1:0] waddr_i,
    input  logic [DW-1:0]  wdata_i,
    input  logic           re_i,
    input  logic [ADW-1:0] raddr_i,
    output logic [DW-1:0]  rdata_o
);

    logic [DW-1:0] mem_q [2**ADW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/pifo_sram_bank.sv
`default_nettype none
// ============================================================================
// Module   : pifo_sram_bank
// Purpose  : Per-level SRAM responder for a PIFO tree. After reset it sweeps
//            every entry to EMPTY_ENTRY, then serves the node's 1-cycle
//            latency read/write stream.
// Config   : PIFO_SRAM_BYPASS_EN - when defined, a same-cycle same-address
//            read+write returns the write data (write-first); otherwise the
//            read returns the pre-write contents (read-first).
// Ports    : i_clk, i_arst (async, active-high)
//            i_read/i_read_addr -> o_read_data (valid after the next edge, held)
//            i_write/i_write_addr/i_write_data
//            o_init_done - high once the init sweep finished
//            o_err       - sticky, set by any request during the init sweep
// Revision : 1.0 - initial release
// ============================================================================
module pifo_sram_bank
    import pifo_sram_pkg::*;
#(
    parameter  int PTW      = 16,
    parameter  int MTW      = 0,
    parameter  int CTW      = 10,
    parameter  int LEVEL    = 4,
    parameter  int TREE_NUM = 4,
    parameter  int SRAM_ADW = $clog2(TREE_NUM / LEVEL) + LEVEL,
    localparam int DW       = calc_dw(PTW, MTW, CTW)
) (
    input  logic                i_clk,
    input  logic                i_arst,
    input  logic                i_read,
    input  logic [SRAM_ADW-1:0] i_read_addr,
    output logic [DW-1:0]       o_read_data,
    input  logic                i_write,
    input  logic [SRAM_ADW-1:0] i_write_addr,
    input  logic [DW-1:0]       i_write_data,
    output logic                o_init_done,
    output logic                o_err
);

    localparam int                DEPTH       = 2 ** SRAM_ADW;
    localparam logic [MAX_DW-1:0] C_EMPTY_WIDE = empty_entry(PTW, MTW, CTW);
    localparam logic [DW-1:0]     EMPTY_ENTRY = C_EMPTY_WIDE[DW-1:0];

    state_e                state_q, state_d;
    logic [SRAM_ADW-1:0]   init_addr_q, init_addr_d;
    logic                  err_q, err_d;
    // Low until the first served read, so o_read_data shows 0 after reset
    // even though the array's read register has no reset.
    logic                  rd_seen_q, rd_seen_d;

    logic                  w_arr_we;
    logic [SRAM_ADW-1:0]   w_arr_waddr;
    logic [DW-1:0]         w_arr_wdata;
    logic                  w_arr_re;
    logic [DW-1:0]         w_arr_rdata;
    logic [DW-1:0]         w_rd_data;
    logic                  w_init_last;

    assign w_init_last = (init_addr_q == SRAM_ADW'(DEPTH - 1));

    // ------------------------------------------------------------------
    // Next-state, init counter, array write mux and error detection
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        err_d       = err_q;
        rd_seen_d   = rd_seen_q;
        w_arr_we    = 1'b0;
        w_arr_waddr = init_addr_q;
        w_arr_wdata = EMPTY_ENTRY;
        w_arr_re    = 1'b0;

        case (state_q)
            ST_INIT: begin
                w_arr_we = 1'b1;
                if (w_init_last) begin
                    state_d = ST_READY;         // counter parks at DEPTH-1
                end else begin
                    init_addr_d = init_addr_q + SRAM_ADW'(1);
                end
                // Requests during the sweep are dropped and flagged.
                if (i_read || i_write) begin
                    err_d = 1'b1;
                end
            end
            ST_READY: begin
                w_arr_we    = i_write;
                w_arr_waddr = i_write_addr;
                w_arr_wdata = i_write_data;
                w_arr_re    = i_read;
                if (i_read) begin
                    rd_seen_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q     <= ST_INIT;
            init_addr_q <= '0;
            err_q       <= 1'b0;
            rd_seen_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
            err_q       <= err_d;
            rd_seen_q   <= rd_seen_d;
        end
    end

    pifo_sram_array #(
        .ADW (SRAM_ADW),
        .DW  (DW)
    ) u_array (
        .clk_i   (i_clk),
        .we_i    (w_arr_we),
        .waddr_i (w_arr_waddr),
        .wdata_i (w_arr_wdata),
        .re_i    (w_arr_re),
        .raddr_i (i_read_addr),
        .rdata_o (w_arr_rdata)
    );

`ifdef PIFO_SRAM_BYPASS_EN
    // Write-first: remember whether the served read collided with the write
    // in the same cycle and, if so, present the write data instead of the
    // (read-first) array output. Updated only on reads so the output holds.
    logic          fwd_q;
    logic [DW-1:0] fwd_data_q;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
        end else if (w_arr_re) begin
            fwd_q      <= i_write && (i_write_addr == i_read_addr);
            fwd_data_q <= i_write_data;
        end
    end

    assign w_rd_data = fwd_q ? fwd_data_q : w_arr_rdata;
`else
    assign w_rd_data = w_arr_rdata;
`endif

    assign o_read_data = rd_seen_q ? w_rd_data : '0;
    assign o_init_done = (state_q == ST_READY);
    assign o_err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pifo_sram_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_pifo_sram_bank
// Purpose  : Self-checking bench for pifo_sram_bank at default parameters
//            (DEPTH=16, entry width 52, EMPTY_HALF = 26'h000FFFF).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pifo_sram_bank;

    localparam int ADW = 4;
    localparam int DW  = 52;

    localparam logic [25:0]   EH = 26'h000FFFF;
    localparam logic [DW-1:0] EE = {EH, EH};
    localparam logic [DW-1:0] V5 = {26'h0010003, 26'h0000007};
    localparam logic [DW-1:0] W9 = {26'h0123456, 26'h0ABCDEF};
    localparam logic [DW-1:0] D1 = 52'h1;
`ifdef PIFO_SRAM_BYPASS_EN
    localparam logic [DW-1:0] SAME3_EXP = D1;
    localparam logic [DW-1:0] SAME5_EXP = W9;
`else
    localparam logic [DW-1:0] SAME3_EXP = EE;
    localparam logic [DW-1:0] SAME5_EXP = V5;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           rd;
    logic [ADW-1:0] raddr;
    logic           wr;
    logic [ADW-1:0] waddr;
    logic [DW-1:0]  wdata;
    logic [DW-1:0]  rdata;
    logic           done;
    logic           err;

    int errors = 0;
    int checks = 0;

    pifo_sram_bank dut (
        .i_clk        (clk),
        .i_arst       (rst),
        .i_read       (rd),
        .i_read_addr  (raddr),
        .o_read_data  (rdata),
        .i_write      (wr),
        .i_write_addr (waddr),
        .i_write_data (wdata),
        .o_init_done  (done),
        .o_err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           rd;
        logic [ADW-1:0] ra;
        logic           wr;
        logic [ADW-1:0] wa;
        logic [DW-1:0]  wd;
        logic           chk;
        logic [DW-1:0]  exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until o_init_done, bounded so a stuck sweep cannot hang.
    task automatic wait_done(output int cnt);
        cnt = 0;
        while (!done && cnt < 40) begin
            tick();
            cnt++;
        end
    endtask

    task automatic idle_inputs();
        rd    = 1'b0;
        raddr = '0;
        wr    = 1'b0;
        waddr = '0;
        wdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;

        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        check("rst_rdata", rdata, '0);
        check_int("rst_done", int'(done), 0);
        check_int("rst_err", int'(err), 0);

        // Release reset away from the edge; sweep must take exactly 16 edges.
        rst = 1'b0;
        wait_done(cnt);
        check_int("init_cycles", cnt, 16);
        check_int("init_err", int'(err), 0);
        check("init_rdata", rdata, '0);

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 16; i++) begin
            vecs.push_back('{1'b1, 4'(i), 1'b0, 4'd0, '0, 1'b1, EE});
        end
        vecs.push_back('{1'b0, 4'd0, 1'b1, 4'd5, V5, 1'b0, '0});  // write 5
        vecs.push_back('{1'b1, 4'd5, 1'b0, 4'd0, '0, 1'b1, V5});  // read-after-write
        vecs.push_back('{1'b1, 4'd3, 1'b1, 4'd3, D1, 1'b1, SAME3_EXP});
        vecs.push_back('{1'b1, 4'd3, 1'b0, 4'd0, '0, 1'b1, D1});
        vecs.push_back('{1'b0, 4'd0, 1'b0, 4'd0, '0, 1'b1, D1});  // no read: hold
        vecs.push_back('{1'b1, 4'd2, 1'b1, 4'd9, W9, 1'b1, EE});  // diff addr
        vecs.push_back('{1'b1, 4'd9, 1'b0, 4'd0, '0, 1'b1, W9});
        vecs.push_back('{1'b1, 4'd2, 1'b0, 4'd0, '0, 1'b1, EE});
        vecs.push_back('{1'b1, 4'd5, 1'b1, 4'd5, W9, 1'b1, SAME5_EXP});
        vecs.push_back('{1'b0, 4'd0, 1'b0, 4'd0, '0, 1'b1, SAME5_EXP});  // hold
        vecs.push_back('{1'b1, 4'd5, 1'b0, 4'd0, '0, 1'b1, W9});

        foreach (vecs[i]) begin
            rd    = vecs[i].rd;
            raddr = vecs[i].ra;
            wr    = vecs[i].wr;
            waddr = vecs[i].wa;
            wdata = vecs[i].wd;
            tick();
            if (vecs[i].chk) begin
                check($sformatf("vec%0d", i), rdata, vecs[i].exp);
            end
        end
        idle_inputs();
        check_int("ready_err", int'(err), 0);

        // ---------------- read during init sets sticky error ----------------
        rst = 1'b1;
        #1;
        check("rst2_rdata", rdata, '0);
        check_int("rst2_done", int'(done), 0);
        tick();
        rst = 1'b0;
        repeat (4) tick();
        rd = 1'b1;
        tick();             // edge 5
        rd = 1'b0;
        check_int("init_rd_err", int'(err), 1);
        check("init_rd_rdata", rdata, '0);
        wait_done(cnt);
        check_int("init_rd_cycles", cnt + 5, 16);
        tick();
        tick();
        check_int("err_sticky", int'(err), 1);
        rd    = 1'b1;
        raddr = 4'd5;
        tick();
        idle_inputs();
        check("resweep_addr5", rdata, EE);

        // ---------------- reset mid-sweep ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        wr    = 1'b1;
        waddr = 4'd7;
        wdata = W9;
        tick();             // edge 4: ignored write, flags error
        idle_inputs();
        check_int("init_wr_err", int'(err), 1);
        repeat (4) tick();  // edge 8
        rst = 1'b1;
        #1;
        check_int("midrst_done", int'(done), 0);
        check_int("midrst_err", int'(err), 0);
        tick();
        rst = 1'b0;
        wait_done(cnt);
        check_int("midrst_cycles", cnt, 16);
        check_int("midrst_err2", int'(err), 0);
        rd    = 1'b1;
        raddr = 4'd7;
        tick();
        idle_inputs();
        check("midrst_addr7", rdata, EE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
